qe_filter: RTL and testbench

QE_FILTER -- requirements
Module: qe_filter

---
 rtl/qe_filter.sv | 177 +++++++++++++++++
 tb/tb_qe_filter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/qe_filter.sv
// Quadrature encoder front end: two-flop pin synchronizers, per-channel glitch
// filters and a registered step/direction decoder with a sticky illegal-transition flag.
module qe_filter #(
  parameter int FW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_a_raw,
  input  logic          i_b_raw,
  input  logic [FW-1:0] i_filt_len,
  input  logic          i_en,
  input  logic          i_err_clr,
  output logic          o_i,
  output logic          o_q,
  output logic          o_step,
  output logic          o_dir,
  output logic          o_err
);

  typedef enum logic [1:0] {
    ST_INIT0 = 2'd0,
    ST_INIT1 = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_a_s1;
  logic          r_a_s2;
  logic          r_b_s1;
  logic          r_b_s2;
  logic [FW-1:0] r_a_cnt;
  logic [FW-1:0] r_b_cnt;
  logic [FW-1:0] w_a_cnt_nxt;
  logic [FW-1:0] w_b_cnt_nxt;
  logic          r_i;
  logic          r_q;
  logic          w_i_nxt;
  logic          w_q_nxt;
  logic [1:0]    r_prev;
  logic [1:0]    w_prev_nxt;
  logic [1:0]    w_cur;
  logic [1:0]    w_dec;
  logic          r_step;
  logic          r_dir;
  logic          r_err;
  logic          w_step_nxt;
  logic          w_dir_nxt;
  logic          w_err_nxt;
  logic [FW:0]   w_a_filt;
  logic [FW:0]   w_b_filt;

  // Returns {next output, next counter}; the output only follows s2 after it
  // has differed for filt_len+1 consecutive enabled cycles.
  function automatic logic [FW:0] filt_step(input logic s2, input logic out,
                                            input logic [FW-1:0] cnt,
                                            input logic [FW-1:0] len);
    logic [FW:0] res;
    if (s2 == out) begin
      res = {out, {FW{1'b0}}};
    end else if (cnt == len) begin
      res = {s2, {FW{1'b0}}};
    end else begin
      res = {out, cnt + FW'(1)};
    end
    return res;
  endfunction

  // Returns {up, down} for a (prev -> cur) move of the {i,q} pair.
  function automatic logic [1:0] quad_dec(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] res;
    case (prev)
      2'b00:   res = {cur == 2'b10, cur == 2'b01};
      2'b10:   res = {cur == 2'b11, cur == 2'b00};
      2'b11:   res = {cur == 2'b01, cur == 2'b10};
      2'b01:   res = {cur == 2'b00, cur == 2'b11};
      default: res = 2'b00;
    endcase
    return res;
  endfunction

  assign w_a_filt = filt_step(r_a_s2, r_i, r_a_cnt, i_filt_len);
  assign w_b_filt = filt_step(r_b_s2, r_q, r_b_cnt, i_filt_len);
  assign w_cur    = {r_i, r_q};
  assign w_dec    = quad_dec(r_prev, w_cur);

  // Next-state logic: startup sequencing, filtering and decoding.
  always_comb begin
    w_state_nxt = r_state;
    w_a_cnt_nxt = r_a_cnt;
    w_b_cnt_nxt = r_b_cnt;
    w_i_nxt     = r_i;
    w_q_nxt     = r_q;
    w_prev_nxt  = r_prev;
    w_step_nxt  = 1'b0;
    w_dir_nxt   = r_dir;
    w_err_nxt   = i_err_clr ? 1'b0 : r_err;
    case (r_state)
      ST_INIT0: begin
        w_state_nxt = ST_INIT1;
      end
      ST_INIT1: begin
        // Seed outputs with the value s2 takes on this edge so nothing looks like a move.
        w_state_nxt = ST_RUN;
        w_i_nxt     = r_a_s1;
        w_q_nxt     = r_b_s1;
        w_prev_nxt  = {r_a_s1, r_b_s1};
        w_a_cnt_nxt = {FW{1'b0}};
        w_b_cnt_nxt = {FW{1'b0}};
      end
      ST_RUN: begin
        w_prev_nxt = w_cur;
        if (i_en) begin
          {w_i_nxt, w_a_cnt_nxt} = w_a_filt;
          {w_q_nxt, w_b_cnt_nxt} = w_b_filt;
          if (w_dec[1]) begin
            w_step_nxt = 1'b1;
            w_dir_nxt  = 1'b1;
          end else if (w_dec[0]) begin
            w_step_nxt = 1'b1;
            w_dir_nxt  = 1'b0;
          end else if (w_cur == ~r_prev) begin
            w_err_nxt = 1'b1;
          end else begin
            w_step_nxt = 1'b0;
          end
        end else begin
          w_a_cnt_nxt = {FW{1'b0}};
          w_b_cnt_nxt = {FW{1'b0}};
        end
      end
      default: begin
        w_state_nxt = ST_INIT0;
      end
    endcase
  end

  // State and datapath registers; synchronizers run whatever the enable says.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT0;
      r_a_s1  <= 1'b0;
      r_a_s2  <= 1'b0;
      r_b_s1  <= 1'b0;
      r_b_s2  <= 1'b0;
      r_a_cnt <= {FW{1'b0}};
      r_b_cnt <= {FW{1'b0}};
      r_i     <= 1'b0;
      r_q     <= 1'b0;
      r_prev  <= 2'b00;
      r_step  <= 1'b0;
      r_dir   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a_s1  <= i_a_raw;
      r_a_s2  <= r_a_s1;
      r_b_s1  <= i_b_raw;
      r_b_s2  <= r_b_s1;
      r_a_cnt <= w_a_cnt_nxt;
      r_b_cnt <= w_b_cnt_nxt;
      r_i     <= w_i_nxt;
      r_q     <= w_q_nxt;
      r_prev  <= w_prev_nxt;
      r_step  <= w_step_nxt;
      r_dir   <= w_dir_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign o_i    = r_i;
  assign o_q    = r_q;
  assign o_step = r_step;
  assign o_dir  = r_dir;
  assign o_err  = r_err;

endmodule

// File: tb/tb_qe_filter.sv
// Directed plus randomized bench for qe_filter, checked every cycle against a
// sample-history reference model of the filter and a successor-table decoder.
module tb_qe_filter;
  localparam int FW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_raw = 1'b0;
  logic          b_raw = 1'b0;
  logic [FW-1:0] filt_len = 4'd0;
  logic          en = 1'b0;
  logic          err_clr = 1'b0;
  logic          o_i, o_q, o_step, o_dir, o_err;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  int n_steps = 0;
  int n_up = 0;
  logic saw_i = 1'b0;

  typedef logic bitq_t[$];

  // Reference model state
  logic [1:0] up_succ [4];
  logic m_s1a, m_s1b, m_s2a, m_s2b;
  logic m_i, m_q, m_step, m_dir, m_err;
  logic [1:0] m_prev;
  int m_edges;
  bitq_t m_ha, m_hb;

  always #5 clk = ~clk;

  qe_filter #(.FW(FW)) dut (
    .clk(clk), .rst_n(rst_n), .i_a_raw(a_raw), .i_b_raw(b_raw),
    .i_filt_len(filt_len), .i_en(en), .i_err_clr(err_clr),
    .o_i(o_i), .o_q(o_q), .o_step(o_step), .o_dir(o_dir), .o_err(o_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // True when the last n synchronized samples all differ from the current output.
  function automatic logic stable_for(input bitq_t h, input logic out, input int n);
    if (h.size() < n) return 1'b0;
    for (int k = 0; k < n; k++) begin
      if (h[h.size() - 1 - k] == out) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic m_reset();
    m_s1a = 1'b0; m_s1b = 1'b0; m_s2a = 1'b0; m_s2b = 1'b0;
    m_i = 1'b0; m_q = 1'b0; m_step = 1'b0; m_dir = 1'b0; m_err = 1'b0;
    m_prev = 2'b00; m_edges = 0;
    m_ha.delete(); m_hb.delete();
  endtask

  task automatic m_edge();
    logic [1:0] cur;
    logic ni, nq;
    int n;
    cur = {m_i, m_q};
    ni = m_i;
    nq = m_q;
    n = int'(filt_len) + 1;
    m_step = 1'b0;
    if (err_clr) m_err = 1'b0;
    if (m_edges == 1) begin
      ni = m_s1a;
      nq = m_s1b;
      m_prev = {m_s1a, m_s1b};
      m_ha.delete(); m_hb.delete();
    end else if (m_edges >= 2) begin
      if (en) begin
        if (cur == up_succ[m_prev]) begin
          m_step = 1'b1; m_dir = 1'b1;
        end else if (m_prev == up_succ[cur]) begin
          m_step = 1'b1; m_dir = 1'b0;
        end else if ((cur ^ m_prev) == 2'b11) begin
          m_err = 1'b1;
        end
        m_prev = cur;
        m_ha.push_back(m_s2a);
        m_hb.push_back(m_s2b);
        if (m_ha.size() > 40) void'(m_ha.pop_front());
        if (m_hb.size() > 40) void'(m_hb.pop_front());
        if (stable_for(m_ha, m_i, n)) begin ni = m_s2a; m_ha.delete(); end
        if (stable_for(m_hb, m_q, n)) begin nq = m_s2b; m_hb.delete(); end
      end else begin
        m_prev = cur;
        m_ha.delete(); m_hb.delete();
      end
    end
    m_i = ni;
    m_q = nq;
    m_s2a = m_s1a; m_s1a = a_raw;
    m_s2b = m_s1b; m_s1b = b_raw;
    if (m_edges < 2) m_edges++;
  endtask

  task automatic cyc();
    @(posedge clk);
    m_edge();
    #1;
    if (o_step) n_steps++;
    if (o_step && o_dir) n_up++;
    if (o_i) saw_i = 1'b1;
    check("model", {27'd0, o_i, o_q, o_step, o_dir, o_err},
                   {27'd0, m_i, m_q, m_step, m_dir, m_err});
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic do_reset(input logic a, input logic b);
    @(negedge clk);
    rst_n = 1'b0;
    a_raw = a;
    b_raw = b;
    m_reset();
    #1;
    check("async_reset", {27'd0, o_i, o_q, o_step, o_dir, o_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    up_succ[0] = 2'b10;
    up_succ[1] = 2'b00;
    up_succ[2] = 2'b11;
    up_succ[3] = 2'b01;
    m_reset();

    // Startup with both pins high
    en = 1'b1;
    filt_len = 4'd0;
    do_reset(1'b1, 1'b1);
    n_steps = 0;
    run(3);
    check("init_third_edge", {28'd0, o_i, o_q, o_step, o_err}, 32'hC);
    check("init_no_step", n_steps, 32'd0);

    // Up sequence with filt_len=3 and latency measurement
    filt_len = 4'd3;
    do_reset(1'b0, 1'b0);
    run(4);
    n_steps = 0; n_up = 0;
    a_raw = 1'b1;
    run(5);
    check("lat_before", {31'd0, o_i}, 32'd0);
    cyc();
    check("lat_at", {31'd0, o_i}, 32'd1);
    run(4);
    b_raw = 1'b1; run(10);
    a_raw = 1'b0; run(10);
    b_raw = 1'b0; run(10);
    check("up_steps", n_steps, 32'd4);
    check("up_dir", n_up, 32'd4);

    // Glitch rejection and minimum accepted pulse
    n_steps = 0; saw_i = 1'b0;
    a_raw = 1'b1; run(3);
    a_raw = 1'b0; run(10);
    check("glitch_steps", n_steps, 32'd0);
    check("glitch_i", {31'd0, saw_i}, 32'd0);
    a_raw = 1'b1; run(4);
    a_raw = 1'b0; run(12);
    check("pulse_steps", n_steps, 32'd2);
    check("pulse_i", {31'd0, saw_i}, 32'd1);

    // Simultaneous change with pass-through filter, then clear
    filt_len = 4'd0;
    n_steps = 0;
    a_raw = 1'b1; b_raw = 1'b1; run(5);
    check("both_err", {31'd0, o_err}, 32'd1);
    check("both_no_step", n_steps, 32'd0);
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    check("err_clr", {31'd0, o_err}, 32'd0);

    // Down sequence with enable dropped while pins move
    filt_len = 4'd2;
    do_reset(1'b0, 1'b0);
    run(4);
    n_steps = 0; n_up = 0;
    b_raw = 1'b1; run(10);
    a_raw = 1'b1; run(10);
    en = 1'b0; n_steps = 0;
    b_raw = 1'b0; run(20);
    check("en_off_steps", n_steps, 32'd0);
    en = 1'b1; n_steps = 0; n_up = 0;
    run(10);
    a_raw = 1'b0; run(10);
    check("resume_steps", n_steps, 32'd2);
    check("resume_dir_down", n_up, 32'd0);

    // Randomized segments; filt_len only changes while counters are held at 0
    for (int seg = 0; seg < 20; seg++) begin
      en = 1'b0; err_clr = 1'b0;
      cyc();
      filt_len = (seg == 7) ? 4'hF : 4'($urandom_range(0, 5));
      en = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < 80; c++) begin
        if ($urandom_range(0, 9) == 0) a_raw = ~a_raw;
        if ($urandom_range(0, 9) == 0) b_raw = ~b_raw;
        err_clr = ($urandom_range(0, 15) == 0);
        cyc();
      end
    end

    // Reset in the middle of a filter count
    en = 1'b0; err_clr = 1'b0; cyc();
    filt_len = 4'd0; en = 1'b1;
    a_raw = 1'b1; b_raw = 1'b1; run(6);
    check("pre_reset_i", {31'd0, o_i}, 32'd1);
    filt_len = 4'd7;
    a_raw = 1'b0; run(3);
    do_reset(1'b1, 1'b1);
    n_steps = 0;
    run(3);
    check("reinit_third_edge", {28'd0, o_i, o_q, o_step, o_err}, 32'hC);
    check("reinit_no_step", n_steps, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
